alu_issue: RTL and testbench
============================

# alu_issue

Issue sequencer that sits between a thread's decode stage and the `Alu`. It accepts one decoded arithmetic or compare request at a time over a valid/ready handshake and drives the `Alu` `io_execute`, `io_operation`, `io_compare`, `io_rs` and `io_rt` inputs. It captures the registered `io_output` one cycle later and returns the result with its destination register index over a second valid/ready handshake. It is the initiator end of the `Alu` interface, and the `Alu` itself is instantiated alongside it by the parent.

## Interface
Parameters:
- `DATA_W`, 8, operand and result width; must match the `Alu`.
- `OP_W`, 4, operation code width.
- `RD_W`, 4, destination register index width.

Ports:
- `clock` input 1. Single clock; all logic is on its rising edge.
- `reset` input 1. Synchronous, active-high.
- `io_req_valid` input 1. A request is offered.
- `io_req_ready` output 1. The block can accept a request.
- `io_req_op` input `OP_W`. ALU operation code.
- `io_req_compare` input 1. Selects compare mode.
- `io_req_rs`, `io_req_rt` input `DATA_W`. Operands.
- `io_req_rd` input `RD_W`. Destination register index.
- `io_alu_execute` output 1. Drives `Alu.io_execute`.
- `io_alu_operation` output `OP_W`; `io_alu_compare` output 1; `io_alu_rs`, `io_alu_rt` output `DATA_W`. Drive the corresponding `Alu` inputs.
- `io_alu_output` input `DATA_W`. Connected to `Alu.io_output`.
- `io_wb_valid` output 1; `io_wb_ready` input 1. Writeback handshake.
- `io_wb_rd` output `RD_W`; `io_wb_data` output `DATA_W`; `io_wb_compare` output 1. Writeback payload.
- `io_busy` output 1. High whenever state is not IDLE.
- `io_issued_count` output 16. Count of completed writebacks.

## Operation
- Request acceptance:
  - FSM states: IDLE, EXEC, WAIT, WB.
  - In IDLE, `io_req_ready`=1. On `io_req_valid && io_req_ready`, latch op, compare, rs, rt and rd, then go to EXEC.
  - `io_req_ready`=0 in every state other than IDLE. Requests offered while busy are not accepted, and the requester must hold them.
- Driving the `Alu`:
  - `io_alu_operation`, `io_alu_compare`, `io_alu_rs` and `io_alu_rt` are driven from the latched registers in every state, so they are stable around the execute cycle.
  - EXEC: `io_alu_execute`=1 for exactly one cycle, then go to WAIT.
  - WAIT: `io_alu_execute`=0. Capture `io_alu_output` into the result register, then go to WB.
- Writeback:
  - WB: `io_wb_valid`=1 with `io_wb_rd`, `io_wb_data` and `io_wb_compare` driven from registers.
  - Stay in WB until `io_wb_ready`=1. On the handshake, go to IDLE and increment `io_issued_count`.
  - While `io_wb_valid`=1 and `io_wb_ready`=0, the payload is held unchanged.
- Counter width: `io_issued_count` wraps from 0xFFFF to 0x0000 with no flag.
- Data width: `io_wb_data` is the `Alu` output verbatim. The block applies no width change, and product truncation is the `Alu`'s responsibility.
- Reset: state goes to IDLE, and all latched and result registers go to 0.
  - Output values under reset: `io_req_ready`=1, `io_alu_execute`=0, `io_wb_valid`=0, `io_busy`=0, `io_issued_count`=0, and all payload outputs 0.
- Reset mid-operation (any non-IDLE state): the transaction is dropped, no writeback is produced and the counter is cleared.
- An undefined `io_req_op` is passed through unchecked.

## Timing
- Cycle 0: handshake (valid and ready both high); the request is latched at the edge ending this cycle.
- Cycle 1: `io_alu_execute`=1.
- Cycle 2: `io_alu_output` is valid and is captured.
- Cycle 3: `io_wb_valid`=1.
- Minimum occupancy is 4 cycles per request, so peak throughput is 1 result per 4 cycles.
- The earliest next request can be accepted in the cycle after the writeback handshake.
- No combinational path exists from any input to any output except `io_req_ready` and `io_busy`, which are decoded from state only.

## Structure
- A shared package `alu_pkg` holds:
  - the state enum (IDLE, EXEC, WAIT, WB);
  - opcode constants `ALU_OP_ADD`=4 and `ALU_OP_MUL`=5;
  - `DATA_W`, `OP_W` and `RD_W` defaults.
- The `Alu` testbench uses the same opcode constants.
- The block is a single module with no sub-module. The FSM and datapath registers are small enough to stay flat.

## Test plan
- Add: req op=4, compare=0, rs=10, rt=3, rd=2, `io_wb_ready`=1.
  - `io_alu_execute` is high exactly on cycle 1.
  - `io_wb_valid` rises on cycle 3 with data=13 (0x0D) and rd=2.
  - `io_issued_count`=1 afterwards.
- Multiply wrap: op=5, rs=255, rt=2 → `io_wb_data`=0xFE.
  - Operands hold 0xFF/0x02 on `io_alu_rs`/`io_alu_rt` from cycle 1 through writeback.
- Backpressure: add 5+5 with `io_wb_ready`=0 for 6 cycles.
  - `io_wb_valid` stays high with data=0x0A and rd stable throughout.
  - `io_req_ready`=0 even while `io_req_valid`=1.
  - On release, the handshake completes and `io_req_ready`=1 the next cycle.
- Back-to-back: the requester holds valid with 4 queued adds.
  - Exactly one `io_alu_execute` pulse per request, spaced 4 cycles apart.
  - Results are returned in order; the count ends at 4.
- Reset mid-op: assert `reset` in the WAIT state.
  - Next cycle: `io_wb_valid`=0, `io_busy`=0, `io_req_ready`=1, count=0.
  - No writeback appears afterwards.
- Counter wrap: force 65536 completed writebacks, or preload via a hierarchical deposit at 0xFFFF and complete one → `io_issued_count`=0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the Alu and its issue sequencer: FSM states,
// opcode constants and default datapath widths.
package alu_pkg;

   localparam int ALU_DATA_W = 8;
   localparam int ALU_OP_W   = 4;
   localparam int ALU_RD_W   = 4;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } state_e;

endpackage

// File: rtl/alu_issue.sv
// Issue sequencer in front of the Alu: latches one request, pulses execute,
// captures the registered Alu result and hands it back with its rd index.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W,
   parameter int RD_W   = ALU_RD_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_req_valid,
   output logic              io_req_ready,
   input  logic [OP_W-1:0]   io_req_op,
   input  logic              io_req_compare,
   input  logic [DATA_W-1:0] io_req_rs,
   input  logic [DATA_W-1:0] io_req_rt,
   input  logic [RD_W-1:0]   io_req_rd,
   output logic              io_alu_execute,
   output logic [OP_W-1:0]   io_alu_operation,
   output logic              io_alu_compare,
   output logic [DATA_W-1:0] io_alu_rs,
   output logic [DATA_W-1:0] io_alu_rt,
   input  logic [DATA_W-1:0] io_alu_output,
   output logic              io_wb_valid,
   input  logic              io_wb_ready,
   output logic [RD_W-1:0]   io_wb_rd,
   output logic [DATA_W-1:0] io_wb_data,
   output logic              io_wb_compare,
   output logic              io_busy,
   output logic [15:0]       io_issued_count
);

   state_e              state_q, state_d;
   logic [OP_W-1:0]     op_q;
   logic                cmp_q;
   logic [DATA_W-1:0]   rs_q, rt_q, res_q;
   logic [RD_W-1:0]     rd_q;
   logic [15:0]         cnt_q, cnt_d;
   logic                req_fire, wb_fire;

   assign req_fire = io_req_valid && (state_q == ST_IDLE);
   assign wb_fire  = io_wb_ready && (state_q == ST_WB);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (io_req_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WAIT;
         ST_WAIT: state_d = ST_WB;
         ST_WB: begin
            if (io_wb_ready) begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operands only move on acceptance, so the Alu inputs and the writeback
   // payload stay frozen for the whole transaction, including backpressure.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         cmp_q   <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (req_fire) begin
            op_q  <= io_req_op;
            cmp_q <= io_req_compare;
            rs_q  <= io_req_rs;
            rt_q  <= io_req_rt;
            rd_q  <= io_req_rd;
         end
         if (state_q == ST_WAIT) res_q <= io_alu_output;
      end
   end

   assign io_req_ready     = (state_q == ST_IDLE);
   assign io_busy          = (state_q != ST_IDLE);
   assign io_alu_execute   = (state_q == ST_EXEC);
   assign io_alu_operation = op_q;
   assign io_alu_compare   = cmp_q;
   assign io_alu_rs        = rs_q;
   assign io_alu_rt        = rt_q;
   assign io_wb_valid      = (state_q == ST_WB);
   assign io_wb_rd         = rd_q;
   assign io_wb_data       = res_q;
   assign io_wb_compare    = cmp_q;
   assign io_issued_count  = cnt_q;

   logic unused_wb_fire;
   assign unused_wb_fire = wb_fire;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small registered Alu model on the
// execute/output side.
module tb_alu_issue;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [3:0]  io_req_op;
   logic        io_req_compare;
   logic [7:0]  io_req_rs, io_req_rt;
   logic [3:0]  io_req_rd;
   logic        io_alu_execute;
   logic [3:0]  io_alu_operation;
   logic        io_alu_compare;
   logic [7:0]  io_alu_rs, io_alu_rt;
   logic [7:0]  io_alu_output;
   logic        io_wb_valid;
   logic        io_wb_ready;
   logic [3:0]  io_wb_rd;
   logic [7:0]  io_wb_data;
   logic        io_wb_compare;
   logic        io_busy;
   logic [15:0] io_issued_count;

   int vec  = 0;
   int miss = 0;

   always #5 clock = ~clock;

   alu_issue dut (
      .clock            (clock),
      .reset            (reset),
      .io_req_valid     (io_req_valid),
      .io_req_ready     (io_req_ready),
      .io_req_op        (io_req_op),
      .io_req_compare   (io_req_compare),
      .io_req_rs        (io_req_rs),
      .io_req_rt        (io_req_rt),
      .io_req_rd        (io_req_rd),
      .io_alu_execute   (io_alu_execute),
      .io_alu_operation (io_alu_operation),
      .io_alu_compare   (io_alu_compare),
      .io_alu_rs        (io_alu_rs),
      .io_alu_rt        (io_alu_rt),
      .io_alu_output    (io_alu_output),
      .io_wb_valid      (io_wb_valid),
      .io_wb_ready      (io_wb_ready),
      .io_wb_rd         (io_wb_rd),
      .io_wb_data       (io_wb_data),
      .io_wb_compare    (io_wb_compare),
      .io_busy          (io_busy),
      .io_issued_count  (io_issued_count)
   );

   // Registered Alu model: compare mode yields 1 when operands are equal.
   always @(posedge clock) begin
      if (reset) io_alu_output <= 8'h00;
      else if (io_alu_execute) begin
         if (io_alu_compare)                     io_alu_output <= {7'b0, io_alu_rs == io_alu_rt};
         else if (io_alu_operation == ALU_OP_ADD) io_alu_output <= io_alu_rs + io_alu_rt;
         else if (io_alu_operation == ALU_OP_MUL) io_alu_output <= io_alu_rs * io_alu_rt;
         else                                     io_alu_output <= 8'h00;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] op, input logic cmp, input logic [7:0] rs,
                            input logic [7:0] rt, input logic [3:0] rd);
      io_req_valid   = 1'b1;
      io_req_op      = op;
      io_req_compare = cmp;
      io_req_rs      = rs;
      io_req_rt      = rt;
      io_req_rd      = rd;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vec++; if (io_req_ready !== 1'b1) begin miss++; $display("FAIL rst_ready got %b want 1", io_req_ready); end
      vec++; if (io_alu_execute !== 1'b0) begin miss++; $display("FAIL rst_exec got %b want 0", io_alu_execute); end
      vec++; if (io_wb_valid !== 1'b0) begin miss++; $display("FAIL rst_wbvalid got %b want 0", io_wb_valid); end
      vec++; if (io_busy !== 1'b0) begin miss++; $display("FAIL rst_busy got %b want 0", io_busy); end
      vec++; if (io_issued_count !== 16'h0000) begin miss++; $display("FAIL rst_count got %h want 0000", io_issued_count); end
      vec++; if ({io_wb_data, io_wb_rd, io_wb_compare, io_alu_rs, io_alu_rt, io_alu_operation, io_alu_compare} !== '0) begin
         miss++; $display("FAIL rst_payload got data=%h rd=%h rs=%h rt=%h op=%h want all 0",
                          io_wb_data, io_wb_rd, io_alu_rs, io_alu_rt, io_alu_operation);
      end
      reset = 1'b0;
   endtask

   task automatic test_add();
      io_wb_ready = 1'b1;
      drive_req(ALU_OP_ADD, 1'b0, 8'd10, 8'd3, 4'd2);
      vec++; if (io_req_ready !== 1'b1) begin miss++; $display("FAIL add_ready_c0 got %b want 1", io_req_ready); end
      vec++; if (io_alu_execute !== 1'b0) begin miss++; $display("FAIL add_exec_c0 got %b want 0", io_alu_execute); end
      tick();
      io_req_valid = 1'b0;
      vec++; if (io_alu_execute !== 1'b1) begin miss++; $display("FAIL add_exec_c1 got %b want 1", io_alu_execute); end
      vec++; if (io_req_ready !== 1'b0) begin miss++; $display("FAIL add_ready_c1 got %b want 0", io_req_ready); end
      tick();
      vec++; if (io_alu_execute !== 1'b0 || io_wb_valid !== 1'b0) begin
         miss++; $display("FAIL add_c2 got exec=%b wbv=%b want 0 0", io_alu_execute, io_wb_valid);
      end
      tick();
      vec++; if (io_wb_valid !== 1'b1) begin miss++; $display("FAIL add_wbvalid_c3 got %b want 1", io_wb_valid); end
      vec++; if (io_wb_data !== 8'h0D) begin miss++; $display("FAIL add_data got %h want 0d", io_wb_data); end
      vec++; if (io_wb_rd !== 4'd2 || io_wb_compare !== 1'b0) begin
         miss++; $display("FAIL add_rd got rd=%0d cmp=%b want 2 0", io_wb_rd, io_wb_compare);
      end
      tick();
      vec++; if (io_wb_valid !== 1'b0 || io_req_ready !== 1'b1) begin
         miss++; $display("FAIL add_c4 got wbv=%b ready=%b want 0 1", io_wb_valid, io_req_ready);
      end
      vec++; if (io_issued_count !== 16'd1) begin miss++; $display("FAIL add_count got %0d want 1", io_issued_count); end
   endtask

   task automatic test_mul_wrap();
      io_wb_ready = 1'b1;
      drive_req(ALU_OP_MUL, 1'b0, 8'hFF, 8'h02, 4'd7);
      tick();
      io_req_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         vec++; if (io_alu_rs !== 8'hFF || io_alu_rt !== 8'h02) begin
            miss++; $display("FAIL mul_operands_c%0d got rs=%h rt=%h want ff 02", c, io_alu_rs, io_alu_rt);
         end
         if (c < 3) tick();
      end
      vec++; if (io_wb_valid !== 1'b1 || io_wb_data !== 8'hFE || io_wb_rd !== 4'd7) begin
         miss++; $display("FAIL mul_wb got v=%b data=%h rd=%0d want 1 fe 7", io_wb_valid, io_wb_data, io_wb_rd);
      end
      tick();
      vec++; if (io_issued_count !== 16'd2) begin miss++; $display("FAIL mul_count got %0d want 2", io_issued_count); end
   endtask

   task automatic test_compare();
      io_wb_ready = 1'b1;
      drive_req(ALU_OP_ADD, 1'b1, 8'd9, 8'd9, 4'd3);
      tick();
      io_req_valid = 1'b0;
      vec++; if (io_alu_compare !== 1'b1) begin miss++; $display("FAIL cmp_alu got %b want 1", io_alu_compare); end
      tick();
      tick();
      vec++; if (io_wb_valid !== 1'b1 || io_wb_compare !== 1'b1 || io_wb_data !== 8'h01 || io_wb_rd !== 4'd3) begin
         miss++; $display("FAIL cmp_wb got v=%b cmp=%b data=%h rd=%0d want 1 1 01 3",
                          io_wb_valid, io_wb_compare, io_wb_data, io_wb_rd);
      end
      tick();
   endtask

   task automatic test_backpressure();
      io_wb_ready = 1'b0;
      drive_req(ALU_OP_ADD, 1'b0, 8'd5, 8'd5, 4'd9);
      tick();
      // A different request is held while the block is busy.
      drive_req(ALU_OP_MUL, 1'b0, 8'd7, 8'd7, 4'd1);
      tick();
      tick();
      for (int c = 0; c < 6; c++) begin
         vec++; if (io_wb_valid !== 1'b1 || io_wb_data !== 8'h0A || io_wb_rd !== 4'd9) begin
            miss++; $display("FAIL bp_hold_%0d got v=%b data=%h rd=%0d want 1 0a 9", c, io_wb_valid, io_wb_data, io_wb_rd);
         end
         vec++; if (io_req_ready !== 1'b0 || io_alu_execute !== 1'b0 || io_alu_operation !== ALU_OP_ADD) begin
            miss++; $display("FAIL bp_busy_%0d got ready=%b exec=%b op=%0d want 0 0 4",
                             c, io_req_ready, io_alu_execute, io_alu_operation);
         end
         if (c == 5) begin
            io_wb_ready  = 1'b1;
            io_req_valid = 1'b0;
         end
         tick();
      end
      vec++; if (io_req_ready !== 1'b1 || io_wb_valid !== 1'b0) begin
         miss++; $display("FAIL bp_release got ready=%b wbv=%b want 1 0", io_req_ready, io_wb_valid);
      end
      vec++; if (io_issued_count !== 16'd4) begin miss++; $display("FAIL bp_count got %0d want 4", io_issued_count); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q_rs [4];
      logic [7:0] q_rt [4];
      logic [7:0] q_exp[4];
      int exec_cyc[8];
      int idx, n_ex, n_wb, cyc;
      logic acc;
      q_rs = '{8'd1, 8'd3, 8'd100, 8'd250};
      q_rt = '{8'd2, 8'd4, 8'd100, 8'd10};
      q_exp = '{8'd3, 8'd7, 8'd200, 8'd4};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      io_wb_ready = 1'b1;
      idx = 0; n_ex = 0; n_wb = 0; cyc = 0;
      drive_req(ALU_OP_ADD, 1'b0, q_rs[0], q_rt[0], 4'd1);
      while (n_wb < 4 && cyc < 60) begin
         if (io_alu_execute === 1'b1 && n_ex < 8) begin exec_cyc[n_ex] = cyc; n_ex++; end
         if (io_wb_valid === 1'b1 && io_wb_ready) begin
            vec++; if (io_wb_data !== q_exp[n_wb] || io_wb_rd !== 4'(n_wb + 1)) begin
               miss++; $display("FAIL b2b_result_%0d got data=%0d rd=%0d want %0d %0d",
                                n_wb, io_wb_data, io_wb_rd, q_exp[n_wb], n_wb + 1);
            end
            n_wb++;
         end
         acc = io_req_valid && io_req_ready;
         tick();
         cyc++;
         if (acc) idx++;
         if (idx < 4) drive_req(ALU_OP_ADD, 1'b0, q_rs[idx], q_rt[idx], 4'(idx + 1));
         else io_req_valid = 1'b0;
      end
      vec++; if (n_wb != 4) begin miss++; $display("FAIL b2b_timeout got %0d results want 4", n_wb); end
      vec++; if (n_ex != 4) begin miss++; $display("FAIL b2b_exec_pulses got %0d want 4", n_ex); end
      for (int i = 0; i < 4 && i < n_ex; i++) begin
         vec++; if (exec_cyc[i] != 1 + 4 * i) begin
            miss++; $display("FAIL b2b_exec_cycle_%0d got %0d want %0d", i, exec_cyc[i], 1 + 4 * i);
         end
      end
      vec++; if (io_issued_count !== 16'd4) begin miss++; $display("FAIL b2b_count got %0d want 4", io_issued_count); end
   endtask

   task automatic test_reset_midop();
      int seen;
      io_wb_ready = 1'b1;
      drive_req(ALU_OP_ADD, 1'b0, 8'd20, 8'd22, 4'd5);
      tick();
      io_req_valid = 1'b0;
      tick();
      vec++; if (io_busy !== 1'b1 || io_alu_execute !== 1'b0) begin
         miss++; $display("FAIL rmid_in_wait got busy=%b exec=%b want 1 0", io_busy, io_alu_execute);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vec++; if (io_wb_valid !== 1'b0 || io_busy !== 1'b0 || io_req_ready !== 1'b1) begin
         miss++; $display("FAIL rmid_state got wbv=%b busy=%b ready=%b want 0 0 1", io_wb_valid, io_busy, io_req_ready);
      end
      vec++; if (io_issued_count !== 16'd0) begin miss++; $display("FAIL rmid_count got %0d want 0", io_issued_count); end
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (io_wb_valid === 1'b1) seen++;
         tick();
      end
      vec++; if (seen != 0) begin miss++; $display("FAIL rmid_no_wb got %0d writeback cycles want 0", seen); end
   endtask

   task automatic test_counter_wrap();
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      #1;
      vec++; if (io_issued_count !== 16'hFFFF) begin miss++; $display("FAIL wrap_preload got %h want ffff", io_issued_count); end
      io_wb_ready = 1'b1;
      drive_req(ALU_OP_ADD, 1'b0, 8'd1, 8'd1, 4'd0);
      tick();
      io_req_valid = 1'b0;
      tick();
      tick();
      tick();
      vec++; if (io_issued_count !== 16'h0000) begin miss++; $display("FAIL wrap_count got %h want 0000", io_issued_count); end
   endtask

   initial begin
      reset          = 1'b1;
      io_req_valid   = 1'b0;
      io_req_op      = '0;
      io_req_compare = 1'b0;
      io_req_rs      = '0;
      io_req_rt      = '0;
      io_req_rd      = '0;
      io_wb_ready    = 1'b0;
      test_reset();
      test_add();
      test_mul_wrap();
      test_compare();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
